reg_file_2r1w: RTL and testbench

- 32-entry x 32-bit register file for the Phase 2 single-cycle MIPS datapath.
- Two combinational read ports and one synchronous write port.
- rd_data2 feeds the ALU-source 2:1 mux (in1 = register, in2 = sign-extended immediate).
- rd_data1 feeds the ALU A input directly.
- Register 0 reads as zero; optional write-to-read bypass.

---
 rtl/reg_file_2r1w_pkg.sv | 13 +
 rtl/reg_file_2r1w_if.sv | 31 +++
 rtl/reg_file_2r1w.sv | 81 ++++++++
 tb/tb_reg_file_2r1w.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and the named
// register indices used around the datapath.
package mips_defs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WR_CNT_W   = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Read/write/debug bundle of the 2-read 1-write register file.
// The master side (datapath or bench) drives addresses and write data.
interface reg_file_2r1w_if
  import mips_defs::*;
#(
  parameter int DW = mips_defs::DATA_W,
  parameter int AW = mips_defs::REG_ADDR_W
);

  logic [AW-1:0]       rd_addr1;
  logic [AW-1:0]       rd_addr2;
  logic [DW-1:0]       rd_data1;
  logic [DW-1:0]       rd_data2;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [AW-1:0]       dbg_addr;
  logic [DW-1:0]       dbg_data;
  logic [WR_CNT_W-1:0] wr_count;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data1, rd_data2, dbg_data, wr_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data1, rd_data2, dbg_data, wr_count
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational read ports with optional same-cycle
// write bypass, one synchronous write port, a debug read port and a write counter.
module reg_file_2r1w
  import mips_defs::*;
#(
  parameter int DATA_W   = mips_defs::DATA_W,
  parameter int ADDR_W   = mips_defs::REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_2r1w_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [WR_CNT_W-1:0] wr_count_q;
  logic [WR_CNT_W-1:0] wr_count_d;
  logic                wr_commit_s;

  function automatic logic is_zero_gated(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // rst_n gates the bypass so a write held during reset never leaks to the reads.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              commit,
    input logic              rst_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] res;
    if (is_zero_gated(addr)) begin
      res = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && commit && rst_ok && (waddr == addr)) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Next-state for the array and the committed-write counter.
  always_comb begin
    wr_commit_s = bus.wr_en && !is_zero_gated(bus.wr_addr);
    mem_d       = mem_q;
    wr_count_d  = wr_count_q;
    if (wr_commit_s) begin
      mem_d[bus.wr_addr] = bus.wr_data;
      wr_count_d         = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Array and counter state; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_count_q <= 16'd0;
    end else begin
      mem_q      <= mem_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.rd_data1 = read_port(bus.rd_addr1, mem_q[bus.rd_addr1], wr_commit_s,
                                  rst_n, bus.wr_addr, bus.wr_data);
  assign bus.rd_data2 = read_port(bus.rd_addr2, mem_q[bus.rd_addr2], wr_commit_s,
                                  rst_n, bus.wr_addr, bus.wr_data);
  assign bus.dbg_data = is_zero_gated(bus.dbg_addr) ? {DATA_W{1'b0}} : mem_q[bus.dbg_addr];
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: one bypassing instance and one
// non-bypassing instance share the same stimulus.
module tb_reg_file_2r1w;
  import mips_defs::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_2r1w_if #(.DW(32), .AW(5)) bus_a ();
  reg_file_2r1w_if #(.DW(32), .AW(5)) bus_b ();

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  assign bus_b.rd_addr1 = bus_a.rd_addr1;
  assign bus_b.rd_addr2 = bus_a.rd_addr2;
  assign bus_b.wr_en    = bus_a.wr_en;
  assign bus_b.wr_addr  = bus_a.wr_addr;
  assign bus_b.wr_data  = bus_a.wr_data;
  assign bus_b.dbg_addr = bus_a.dbg_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = addr;
    bus_a.wr_data = data;
    @(posedge clk);
    #1;
    bus_a.wr_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with a write pending: nothing may land.
    rst_n          = 1'b0;
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd5;
    bus_a.wr_data  = 32'hDEADBEEF;
    bus_a.rd_addr1 = 5'd5;
    bus_a.rd_addr2 = 5'd5;
    bus_a.dbg_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd1_held", bus_a.rd_data1, 32'd0);
    check("reset_cnt_held", {16'd0, bus_a.wr_count}, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus_a.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("reset_rd1_after", bus_a.rd_data1, 32'd0);
    check("reset_cnt_after", {16'd0, bus_a.wr_count}, 32'd0);

    // Basic write/read on consecutive edges.
    write_reg(REG_T0, 32'd452);
    write_reg(5'd9, 32'd167);
    bus_a.rd_addr1 = REG_T0;
    bus_a.rd_addr2 = 5'd9;
    #1;
    check("basic_rd1", bus_a.rd_data1, 32'd452);
    check("basic_rd2", bus_a.rd_data2, 32'd167);
    check("basic_cnt", {16'd0, bus_a.wr_count}, 32'd2);
    check("basic_nb_rd2", bus_b.rd_data2, 32'd167);

    // Zero register discards writes and always reads 0.
    @(negedge clk);
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = REG_ZERO;
    bus_a.wr_data  = 32'hFFFFFFFF;
    bus_a.rd_addr1 = REG_ZERO;
    bus_a.dbg_addr = REG_ZERO;
    #1;
    check("zero_rd1_pre", bus_a.rd_data1, 32'd0);
    @(posedge clk);
    #1;
    bus_a.wr_en = 1'b0;
    #1;
    check("zero_rd1_post", bus_a.rd_data1, 32'd0);
    check("zero_dbg_post", bus_a.dbg_data, 32'd0);
    check("zero_cnt", {16'd0, bus_a.wr_count}, 32'd2);

    // Bypass: same-cycle write to the addressed entry.
    write_reg(5'd10, 32'd252);
    @(negedge clk);
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd10;
    bus_a.wr_data  = 32'd65;
    bus_a.rd_addr1 = 5'd10;
    bus_a.rd_addr2 = 5'd10;
    bus_a.dbg_addr = 5'd10;
    #1;
    check("byp_rd1_pre", bus_a.rd_data1, 32'd65);
    check("byp_rd2_pre", bus_a.rd_data2, 32'd65);
    check("byp_dbg_pre", bus_a.dbg_data, 32'd252);
    check("nobyp_rd1_pre", bus_b.rd_data1, 32'd252);
    check("nobyp_rd2_pre", bus_b.rd_data2, 32'd252);
    @(posedge clk);
    #1;
    bus_a.wr_en = 1'b0;
    #1;
    check("byp_dbg_post", bus_a.dbg_data, 32'd65);
    check("byp_cnt", {16'd0, bus_a.wr_count}, 32'd4);

    // Write to one address while reading others: no interaction.
    @(negedge clk);
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = 5'd11;
    bus_a.wr_data  = 32'h0000_1234;
    bus_a.rd_addr1 = REG_T0;
    bus_a.rd_addr2 = 5'd9;
    #1;
    check("indep_rd1", bus_a.rd_data1, 32'd452);
    check("indep_rd2", bus_a.rd_data2, 32'd167);
    @(posedge clk);
    #1;
    bus_a.wr_en    = 1'b0;
    bus_a.rd_addr1 = 5'd11;
    #1;
    check("indep_r11", bus_a.rd_data1, 32'h0000_1234);

    // Asynchronous reset pulse between clock edges.
    write_reg(REG_RA, 32'd2);
    bus_a.rd_addr1 = REG_RA;
    #1;
    check("ra_before_rst", bus_a.rd_data1, 32'd2);
    rst_n = 1'b0;
    #2;
    check("ra_during_rst", bus_a.rd_data1, 32'd0);
    check("cnt_during_rst", {16'd0, bus_a.wr_count}, 32'd0);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ra_after_rst", bus_a.rd_data1, 32'd0);
    check("cnt_after_rst", {16'd0, bus_a.wr_count}, 32'd0);

    // Counter wrap after 65536 committed writes.
    bus_a.rd_addr1 = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) begin
        check("cnt_before_wrap", {16'd0, bus_a.wr_count}, 32'h0000_FFFF);
      end
      write_reg(5'd1, 32'h1000_0000 + i);
    end
    #1;
    check("cnt_wrapped", {16'd0, bus_a.wr_count}, 32'd0);
    check("r1_last", bus_a.rd_data1, 32'h1000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
